sub_word_d_mem_write_rv: RTL and testbench
==========================================

SUB_WORD_D_MEM_WRITE_RV -- requirements
Module: sub_word_d_mem_write_rv

Interface
REQ-001 SHALL: iwClock  input  1  single clock, all state changes on rising edge.
REQ-002 SHALL: iwnReset  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: iwStart  input  1  store request strobe, sampled only in IDLE.
REQ-004 SHALL: iwAddress  input  32  byte address of store.
REQ-005 SHALL: iwValue  input  32  store data, payload in low bits.
REQ-006 SHALL: iwDMemAccess  input  2  access size, `MEM_ACCESS_BYTE / `MEM_ACCESS_HALF_WORD; any other code = word.
REQ-007 SHALL: owMemAddress  output  32  word-aligned memory address, low 2 bits zero.
REQ-008 SHALL: owMemReadEnable  output  1  word read request; data returns next cycle.
REQ-009 SHALL: iwMemReadData  input  32  read data, valid the cycle after owMemReadEnable.
REQ-010 SHALL: owMemWriteEnable  output  1  full-word write strobe (memory has no byte enables).
REQ-011 SHALL: owMemWriteData  output  32  merged word to write.
REQ-012 SHALL: owBusy  output  1  high whenever state is not IDLE.
REQ-013 SHALL: owDone  output  1  one-cycle pulse, store committed this cycle.
REQ-014 SHALL: owMisaligned  output  1  one-cycle pulse, store rejected for alignment.

Function
REQ-015 SHALL: states IDLE, READ, MERGE, WRITE, FAULT.
REQ-016 SHALL: IDLE with iwStart=1 latches address, value, access size; iwStart while busy is ignored.
REQ-017 SHALL: alignment check at accept -- half with iwAddress[0]=1, or word with iwAddress[1:0]!=0, goes to FAULT; byte never faults.
REQ-018 SHALL: aligned word store goes IDLE->WRITE, write data = latched value unchanged, no read issued.
REQ-019 SHALL: aligned byte/half store goes IDLE->READ->MERGE->WRITE.
REQ-020 SHALL: READ asserts owMemReadEnable=1 with owMemAddress={addr[31:2],2'b00}.
REQ-021 SHALL: MERGE captures iwMemReadData and replaces one lane: byte lane k=addr[1:0] bits [8k+7:8k] <= value[7:0]; half lane k=addr[1] bits [16k+15:16k] <= value[15:0]; other bits preserved.
REQ-022 SHALL: WRITE asserts owMemWriteEnable=1, owDone=1, presents merged word and aligned address, then returns to IDLE.
REQ-023 SHALL: FAULT asserts owMisaligned=1 for one cycle, no memory strobe, then returns to IDLE.
REQ-024 SHALL: latency from accept edge: word done 1 cycle, byte/half done 3 cycles, fault pulse 1 cycle.
REQ-025 SHALL: owMemReadEnable and owMemWriteEnable never high in the same cycle; both low in IDLE.
REQ-026 SHALL: iwStart may be re-asserted in the cycle after WRITE/FAULT (back-to-back, one idle cycle).

Reset
REQ-027 SHALL: reset assertion at any time forces IDLE asynchronously, aborting any store with no write issued.
REQ-028 SHALL: reset values -- owMemAddress=0, owMemWriteData=0, all strobes/owBusy/owDone/owMisaligned=0, latched registers 0.

Structure
REQ-029 SHALL: state encodings defined beside the access codes in macros/control.v, shared with the read path.
REQ-030 SHALL: lane replacement implemented in combinational sub-module sub_word_merge_rv (word, value, offset, size -> merged word).

Verification
REQ-031 SHALL: byte store addr 0x103, value 0xAB, read data 0x11223344 -> READ at 0x100, write 0xAB223344 three cycles after accept, owDone once.
REQ-032 SHALL: half store addr 0x202, value 0xBEEF, read data 0xCAFEF00D -> write 0xBEEFF00D at 0x200.
REQ-033 SHALL: word store addr 0x300, value 0xDEADBEEF -> no read, write 0xDEADBEEF at 0x300 one cycle after accept.
REQ-034 SHALL: half at 0x401 and word at 0x402 -> owMisaligned pulse each, no read/write strobes.
REQ-035 SHALL: iwnReset low during MERGE of a byte store -> immediate IDLE, no owMemWriteEnable, outputs at reset values.
REQ-036 SHALL: iwStart held high during a byte store -> second request accepted only in IDLE after WRITE.

Source files
------------

// File: rtl/sub_word_d_mem_write_rv_pkg.sv
// sub_word_d_mem_write_rv_pkg: access-size codes and store FSM encodings shared with the read path.
package sub_word_d_mem_write_rv_pkg;
    localparam logic [1:0] MEM_ACCESS_BYTE      = 2'b00;
    localparam logic [1:0] MEM_ACCESS_HALF_WORD = 2'b01;
    localparam logic [1:0] MEM_ACCESS_WORD      = 2'b10;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_MERGE = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;
endpackage

// File: rtl/sub_word_merge_rv.sv
// sub_word_merge_rv: replaces one byte or halfword lane of a memory word with store data.
module sub_word_merge_rv
    import sub_word_d_mem_write_rv_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] value_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    output logic [31:0] merged_o
);
    always_comb begin
        merged_o = word_i;
        if (size_i == MEM_ACCESS_BYTE)
            merged_o[{offset_i, 3'b000} +: 8] = value_i[7:0];
        else if (size_i == MEM_ACCESS_HALF_WORD)
            merged_o[{offset_i[1], 4'b0000} +: 16] = value_i[15:0];
        else
            merged_o = value_i;
    end
endmodule

// File: rtl/sub_word_d_mem_write_rv.sv
// sub_word_d_mem_write_rv: byte/half/word store engine for a memory without byte enables;
// sub-word stores do read-modify-write, misaligned half/word stores are rejected.
module sub_word_d_mem_write_rv
    import sub_word_d_mem_write_rv_pkg::*;
(
    input  logic        iwClock,
    input  logic        iwnReset,
    input  logic        iwStart,
    input  logic [31:0] iwAddress,
    input  logic [31:0] iwValue,
    input  logic [1:0]  iwDMemAccess,
    output logic [31:0] owMemAddress,
    output logic        owMemReadEnable,
    input  logic [31:0] iwMemReadData,
    output logic        owMemWriteEnable,
    output logic [31:0] owMemWriteData,
    output logic        owBusy,
    output logic        owDone,
    output logic        owMisaligned
);
    logic [2:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] merged;
    logic        is_byte, is_half, misaligned;

    assign is_byte    = iwDMemAccess == MEM_ACCESS_BYTE;
    assign is_half    = iwDMemAccess == MEM_ACCESS_HALF_WORD;
    assign misaligned = is_half ? iwAddress[0] : (!is_byte && iwAddress[1:0] != 2'b00);

    sub_word_merge_rv u_merge (
        .word_i   (iwMemReadData),
        .value_i  (wdata_q),
        .offset_i (addr_q[1:0]),
        .size_i   (size_q),
        .merged_o (merged)
    );

    // wdata_q holds the raw store value until MERGE overwrites it with the merged word
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        if (state_q == S_IDLE && iwStart) begin
            addr_d  = iwAddress;
            size_d  = iwDMemAccess;
            wdata_d = iwValue;
            state_d = misaligned ? S_FAULT : (is_byte || is_half) ? S_READ : S_WRITE;
        end else if (state_q == S_READ) begin
            state_d = S_MERGE;
        end else if (state_q == S_MERGE) begin
            wdata_d = merged;
            state_d = S_WRITE;
        end else if (state_q != S_IDLE) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge iwClock or negedge iwnReset) begin
        if (!iwnReset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
        end
    end

    assign owMemAddress     = {addr_q[31:2], 2'b00};
    assign owMemWriteData   = wdata_q;
    assign owMemReadEnable  = state_q == S_READ;
    assign owMemWriteEnable = state_q == S_WRITE;
    assign owDone           = state_q == S_WRITE;
    assign owMisaligned     = state_q == S_FAULT;
    assign owBusy           = state_q != S_IDLE;
endmodule

// File: tb/tb_sub_word_d_mem_write_rv.sv
// tb_sub_word_d_mem_write_rv: directed store sequences with hand-computed memory traffic.
module tb_sub_word_d_mem_write_rv;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] addr, value, rdata;
    logic [1:0]  acc;
    logic [31:0] mem_addr, mem_wdata;
    logic        re, we, busy, done, mis;
    logic [4:0]  flags;
    int          n_tests = 0;
    int          n_fail  = 0;

    localparam logic [4:0] F_IDLE  = 5'b00000;
    localparam logic [4:0] F_READ  = 5'b10001;
    localparam logic [4:0] F_MERGE = 5'b00001;
    localparam logic [4:0] F_WRITE = 5'b01101;
    localparam logic [4:0] F_FAULT = 5'b00011;

    sub_word_d_mem_write_rv dut (
        .iwClock          (clk),
        .iwnReset         (rst_n),
        .iwStart          (start),
        .iwAddress        (addr),
        .iwValue          (value),
        .iwDMemAccess     (acc),
        .owMemAddress     (mem_addr),
        .owMemReadEnable  (re),
        .iwMemReadData    (rdata),
        .owMemWriteEnable (we),
        .owMemWriteData   (mem_wdata),
        .owBusy           (busy),
        .owDone           (done),
        .owMisaligned     (mis)
    );

    always #5 clk = ~clk;
    assign flags = {re, we, done, mis, busy};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] a, input logic [31:0] v, input logic [1:0] s);
        start = 1'b1;
        addr  = a;
        value = v;
        acc   = s;
    endtask

    task automatic sub_store(input string tag, input logic [31:0] a, input logic [31:0] v,
                             input logic [1:0] s, input logic [31:0] rd, input logic [31:0] exp_w);
        accept(a, v, s);
        tick();
        start = 1'b0;
        rdata = 32'hFFFF_FFFF;
        chk({tag, " read flags"}, {27'd0, flags}, {27'd0, F_READ});
        chk({tag, " read addr"}, mem_addr, {a[31:2], 2'b00});
        tick();
        rdata = rd;
        chk({tag, " merge flags"}, {27'd0, flags}, {27'd0, F_MERGE});
        tick();
        rdata = 32'h0;
        chk({tag, " write flags"}, {27'd0, flags}, {27'd0, F_WRITE});
        chk({tag, " write data"}, mem_wdata, exp_w);
        chk({tag, " write addr"}, mem_addr, {a[31:2], 2'b00});
        tick();
        chk({tag, " idle flags"}, {27'd0, flags}, {27'd0, F_IDLE});
    endtask

    task automatic word_store(input string tag, input logic [31:0] a, input logic [31:0] v,
                              input logic [1:0] s);
        accept(a, v, s);
        tick();
        start = 1'b0;
        chk({tag, " write flags"}, {27'd0, flags}, {27'd0, F_WRITE});
        chk({tag, " write data"}, mem_wdata, v);
        chk({tag, " write addr"}, mem_addr, a);
        tick();
        chk({tag, " idle flags"}, {27'd0, flags}, {27'd0, F_IDLE});
    endtask

    task automatic fault_store(input string tag, input logic [31:0] a, input logic [1:0] s);
        accept(a, 32'h1234_5678, s);
        tick();
        start = 1'b0;
        chk({tag, " fault flags"}, {27'd0, flags}, {27'd0, F_FAULT});
        tick();
        chk({tag, " idle flags"}, {27'd0, flags}, {27'd0, F_IDLE});
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        addr  = '0;
        value = '0;
        acc   = 2'b00;
        rdata = '0;
        #1;
        chk("reset flags", {27'd0, flags}, {27'd0, F_IDLE});
        chk("reset addr", mem_addr, 32'h0);
        chk("reset wdata", mem_wdata, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post-reset idle", {27'd0, flags}, {27'd0, F_IDLE});

        sub_store("byte 0x103", 32'h103, 32'h0000_00AB, 2'b00, 32'h1122_3344, 32'hAB22_3344);
        sub_store("byte 0x101", 32'h101, 32'h7777_77CD, 2'b00, 32'h1122_3344, 32'h1122_CD44);
        sub_store("half 0x202", 32'h202, 32'h0000_BEEF, 2'b01, 32'hCAFE_F00D, 32'hBEEF_F00D);
        sub_store("half 0x200", 32'h200, 32'h5555_1234, 2'b01, 32'hCAFE_F00D, 32'hCAFE_1234);
        word_store("word 0x300", 32'h300, 32'hDEAD_BEEF, 2'b10);
        word_store("word code3 0x500", 32'h500, 32'h1234_5678, 2'b11);
        fault_store("half 0x401", 32'h401, 2'b01);
        fault_store("word 0x402", 32'h402, 2'b10);
        fault_store("word 0x403", 32'h403, 2'b10);

        // reset asserted in the middle of a byte store's MERGE cycle
        accept(32'h103, 32'h0000_00AB, 2'b00);
        tick();
        start = 1'b0;
        tick();
        rdata = 32'h1122_3344;
        chk("abort in merge", {27'd0, flags}, {27'd0, F_MERGE});
        rst_n = 1'b0;
        #1;
        chk("abort flags", {27'd0, flags}, {27'd0, F_IDLE});
        chk("abort addr", mem_addr, 32'h0);
        chk("abort wdata", mem_wdata, 32'h0);
        tick();
        chk("abort held no write", {27'd0, flags}, {27'd0, F_IDLE});
        rst_n = 1'b1;
        tick();
        chk("abort after release", {27'd0, flags}, {27'd0, F_IDLE});

        // start held high: second request only accepted from IDLE after WRITE
        accept(32'h102, 32'h0000_0099, 2'b00);
        tick();
        rdata = 32'hFFFF_FFFF;
        chk("b2b read", {27'd0, flags}, {27'd0, F_READ});
        tick();
        rdata = 32'hAABB_CCDD;
        chk("b2b merge", {27'd0, flags}, {27'd0, F_MERGE});
        tick();
        rdata = 32'h0;
        chk("b2b write", {27'd0, flags}, {27'd0, F_WRITE});
        chk("b2b wdata", mem_wdata, 32'hAA99_CCDD);
        tick();
        chk("b2b idle gap", {27'd0, flags}, {27'd0, F_IDLE});
        tick();
        start = 1'b0;
        chk("b2b second read", {27'd0, flags}, {27'd0, F_READ});
        tick();
        rdata = 32'h0102_0304;
        chk("b2b second merge", {27'd0, flags}, {27'd0, F_MERGE});
        tick();
        chk("b2b second write", {27'd0, flags}, {27'd0, F_WRITE});
        chk("b2b second wdata", mem_wdata, 32'h0199_0304);
        tick();
        chk("b2b final idle", {27'd0, flags}, {27'd0, F_IDLE});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
